// File: rtl/div_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_seq_ctrl_pkg
// Description : Shared types and constants for the EX-stage divide sequencer
//               and its iterative core.
// Revision    : 1.0 - initial release
// ============================================================================
package div_seq_ctrl_pkg;

    // Op code bits: [0] unsigned, [1] remainder, [2] word form
    typedef logic [2:0] div_op_t;

    localparam int OP_UNS  = 0;
    localparam int OP_REM  = 1;
    localparam int OP_WORD = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    // Iteration counts for word and doubleword divides
    localparam int DIV_CYC_W = 32;
    localparam int DIV_CYC_D = 64;

    // Most negative values at each operand width
    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
    localparam logic [31:0] MIN32 = 32'h8000_0000;

endpackage : div_seq_ctrl_pkg
`default_nettype wire

// File: rtl/div_iter_core.sv
`default_nettype none
// ============================================================================
// Module      : div_iter_core
// Description : Restoring radix-2 unsigned divider, one quotient bit per
//               cycle. Word-length divides pre-shift the dividend so only 32
//               steps are needed. done is high during the final step; quot
//               and rem are valid from the following cycle until next start.
// Revision    : 1.0 - initial release
// ============================================================================
module div_iter_core
    import div_seq_ctrl_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int CNT_W = 7
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            abort,
    input  logic            len_w,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            done,
    output logic [XLEN-1:0] quot,
    output logic [XLEN-1:0] rem
);

    localparam int c_HALF = XLEN / 2;

    logic             r_busy;
    logic [CNT_W-1:0] r_cnt;
    logic [XLEN-1:0]  r_quot;
    logic [XLEN-1:0]  r_rem;
    logic [XLEN-1:0]  r_div;

    logic [XLEN:0]    w_rem_sh;
    logic             w_ge;
    logic [XLEN:0]    w_diff;

    // Partial remainder is one bit wider than XLEN so the shift never overflows
    assign w_rem_sh = {r_rem, r_quot[XLEN-1]};
    assign w_ge     = (w_rem_sh >= {1'b0, r_div});
    assign w_diff   = w_rem_sh - {1'b0, r_div};

    assign done = r_busy && (r_cnt == CNT_W'(1));
    assign quot = r_quot;
    assign rem  = r_rem;

    // Load on start, then shift-subtract one bit per cycle until the count runs out
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_quot <= '0;
            r_rem  <= '0;
            r_div  <= '0;
        end else if (abort) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end else if (start) begin
            r_busy <= 1'b1;
            r_cnt  <= len_w ? CNT_W'(DIV_CYC_W) : CNT_W'(DIV_CYC_D);
            r_quot <= len_w ? {dividend[c_HALF-1:0], {c_HALF{1'b0}}} : dividend;
            r_rem  <= '0;
            r_div  <= divisor;
        end else if (r_busy) begin
            r_rem  <= w_ge ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
            r_quot <= {r_quot[XLEN-2:0], w_ge};
            r_cnt  <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule : div_iter_core
`default_nettype wire

// File: rtl/div_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : div_seq_ctrl
// Description : EX-stage divide sequencer. Conditions operands and signs,
//               resolves divide-by-zero and signed overflow on a 1-cycle fast
//               path, otherwise runs div_iter_core, applies the sign fix-up,
//               holds the result until consumed and drives the EX stall.
// Revision    : 1.0 - initial release
// ============================================================================
module div_seq_ctrl
    import div_seq_ctrl_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int HALF  = 32,
    parameter int CNT_W = 7
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  div_op_t         req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic            stall_o
);

    function automatic logic [XLEN-1:0] sext_half(input logic [HALF-1:0] v);
        return {{(XLEN-HALF){v[HALF-1]}}, v};
    endfunction

    div_state_t       r_state;
    div_state_t       w_next_state;

    logic             r_word;
    logic             r_rem_op;
    logic             r_q_neg;
    logic             r_r_neg;
    logic [CNT_W-1:0] r_cnt;
    logic [XLEN-1:0]  r_resp_data;

    logic             w_word;
    logic             w_uns;
    logic             w_rem_op;
    logic [XLEN-1:0]  w_a_ext;
    logic [XLEN-1:0]  w_b_ext;
    logic             w_sa;
    logic             w_sb;
    logic [XLEN-1:0]  w_a_abs;
    logic [XLEN-1:0]  w_b_abs;
    logic [XLEN-1:0]  w_min;
    logic             w_b_zero;
    logic             w_ovf;
    logic             w_fast;
    logic [XLEN-1:0]  w_fast_res;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_core_start;
    logic             w_core_abort;
    logic             w_core_done;
    logic [XLEN-1:0]  w_core_quot;
    logic [XLEN-1:0]  w_core_rem;
    logic [XLEN-1:0]  w_sel;
    logic [XLEN-1:0]  w_fix;

    // ---------------- operand conditioning ----------------
    assign w_word   = req_op[OP_WORD];
    assign w_uns    = req_op[OP_UNS];
    assign w_rem_op = req_op[OP_REM];

    assign w_a_ext = !w_word ? req_a :
                     w_uns   ? {{(XLEN-HALF){1'b0}}, req_a[HALF-1:0]} : sext_half(req_a[HALF-1:0]);
    assign w_b_ext = !w_word ? req_b :
                     w_uns   ? {{(XLEN-HALF){1'b0}}, req_b[HALF-1:0]} : sext_half(req_b[HALF-1:0]);

    assign w_sa    = !w_uns && w_a_ext[XLEN-1];
    assign w_sb    = !w_uns && w_b_ext[XLEN-1];
    assign w_a_abs = w_sa ? -w_a_ext : w_a_ext;
    assign w_b_abs = w_sb ? -w_b_ext : w_b_ext;

    // Special cases resolved without the core
    assign w_min    = w_word ? sext_half(MIN32) : MIN64;
    assign w_b_zero = (w_b_ext == '0);
    assign w_ovf    = !w_uns && (w_a_ext == w_min) && (w_b_ext == '1);
    assign w_fast   = w_b_zero || w_ovf;

    // Divide-by-zero wins over overflow (b=0 and b=-1 are exclusive anyway)
    assign w_fast_res = w_b_zero ? (w_rem_op ? (w_word ? sext_half(req_a[HALF-1:0]) : req_a) : '1)
                                 : (w_rem_op ? '0 : w_min);

    // Counter reaches zero exactly as the last ITER cycle's decrement lands
    assign w_cnt_next = r_cnt - CNT_W'(1);

    // ---------------- sign fix-up ----------------
    assign w_sel = r_rem_op ? (r_r_neg ? -w_core_rem  : w_core_rem)
                            : (r_q_neg ? -w_core_quot : w_core_quot);
    assign w_fix = r_word ? sext_half(w_sel[HALF-1:0]) : w_sel;

    assign resp_data = r_resp_data;

    div_iter_core #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .start    (w_core_start),
        .abort    (w_core_abort),
        .len_w    (w_word),
        .dividend (w_a_abs),
        .divisor  (w_b_abs),
        .done     (w_core_done),
        .quot     (w_core_quot),
        .rem      (w_core_rem)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and handshake outputs; flush overrides everything
    always_comb begin
        w_next_state = r_state;
        req_ready    = 1'b0;
        stall_o      = 1'b0;
        resp_valid   = 1'b0;
        w_core_start = 1'b0;
        w_core_abort = flush;
        case (r_state)
            IDLE: begin
                if (req_valid && !flush) begin
                    req_ready    = 1'b1;
                    stall_o      = 1'b1;
                    w_core_start = !w_fast;
                    w_next_state = w_fast ? DONE : ITER;
                end
            end
            ITER: begin
                stall_o = 1'b1;
                if (w_core_done && (w_cnt_next == '0)) begin
                    w_next_state = FIX;
                end
            end
            FIX: begin
                stall_o      = 1'b1;
                w_next_state = DONE;
            end
            DONE: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
        if (flush) begin
            w_next_state = IDLE;
        end
    end

    // Op latch, iteration counter and result register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_word      <= 1'b0;
            r_rem_op    <= 1'b0;
            r_q_neg     <= 1'b0;
            r_r_neg     <= 1'b0;
            r_cnt       <= '0;
            r_resp_data <= '0;
        end else if (flush) begin
            r_cnt <= '0;
        end else begin
            if (req_ready) begin
                r_word   <= w_word;
                r_rem_op <= w_rem_op;
                r_q_neg  <= w_sa ^ w_sb;
                r_r_neg  <= w_sa;
                if (w_fast) begin
                    r_resp_data <= w_fast_res;
                end else begin
                    r_cnt <= w_word ? CNT_W'(DIV_CYC_W) : CNT_W'(DIV_CYC_D);
                end
            end else if ((r_state == ITER) && (r_cnt != '0)) begin
                r_cnt <= w_cnt_next;
            end
            if (r_state == FIX) begin
                r_resp_data <= w_fix;
            end
        end
    end

    // The core's done pulse must land on the same cycle the counter expires
    always_ff @(posedge clk) begin
        if (!reset && !flush && (r_state == ITER)) begin
            assert (w_core_done == (w_cnt_next == '0));
        end
    end

endmodule : div_seq_ctrl
`default_nettype wire

// File: tb/tb_div_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_seq_ctrl
// Description : Scoreboard bench for div_seq_ctrl. Directed ops push their
//               expected result and latency; a monitor compares on each new
//               resp_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_data;
    logic        stall_o;

    typedef struct {
        string       name;
        logic [63:0] data;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;
    logic prev_valid = 1'b0;

    div_seq_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .stall_o    (stall_o)
    );

    always #5 clk = ~clk;

    // Cycle number: at the negedge of cycle n this reads n
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare each newly presented response against the scoreboard
    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset) begin
            prev_valid = 1'b0;
        end else begin
            if (resp_valid && !prev_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got data=%h, required no response", resp_data);
                end else begin
                    e = sb.pop_front();
                    checks++;
                    if (resp_data !== e.data) begin
                        errors++;
                        $display("FAIL %s_data: got %h, required %h", e.name, resp_data, e.data);
                    end
                    checks++;
                    if ((cyc - e.acc) != e.lat) begin
                        errors++;
                        $display("FAIL %s_latency: got %0d, required %0d", e.name, cyc - e.acc, e.lat);
                    end
                end
            end
            prev_valid = resp_valid;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp_v);
        end
    endtask

    // Present an op, wait (bounded) for acceptance, optionally push its expectation.
    // Returns at the negedge of the cycle after acceptance; acc is the accept cycle.
    task automatic issue(input string name, input logic [2:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] exp_d, input int lat,
                         input bit want, output int acc);
        bit   got;
        exp_t e;
        acc = 0;
        got = 1'b0;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        for (int i = 0; i < 20 && !got; i++) begin
            #1;
            if (req_ready) got = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s_accept: got req_ready=0, required 1 within 20 cycles", name);
            req_valid = 1'b0;
            return;
        end
        chk({name, "_stall_accept"}, {63'd0, stall_o}, 64'd1);
        acc = cyc;
        if (want) begin
            e.name = name;
            e.data = exp_d;
            e.acc  = acc;
            e.lat  = lat;
            sb.push_back(e);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            #2;
            if (sb.size() == 0 && !resp_valid) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_timeout: got no completed response, required one within 200 cycles", name);
        end
    endtask

    task automatic run(input string name, input logic [2:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp_d, input int lat);
        int acc;
        issue(name, op, a, b, exp_d, lat, 1'b1, acc);
        wait_done(name);
    endtask

    // Op codes: [0] unsigned, [1] remainder, [2] word
    localparam logic [2:0] OP_DIV   = 3'b000;
    localparam logic [2:0] OP_DIVU  = 3'b001;
    localparam logic [2:0] OP_REM   = 3'b010;
    localparam logic [2:0] OP_REMU  = 3'b011;
    localparam logic [2:0] OP_DIVW  = 3'b100;
    localparam logic [2:0] OP_DIVUW = 3'b101;
    localparam logic [2:0] OP_REMW  = 3'b110;
    localparam logic [2:0] OP_REMUW = 3'b111;

    initial begin : stim
        int acc;
        int lows;
        int bad;
        int hits;
        bit seen;

        reset      = 1'b1;
        flush      = 1'b0;
        req_valid  = 1'b0;
        req_op     = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_req_ready",  {63'd0, req_ready},  64'd0);
        chk("reset_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("reset_resp_data",  resp_data,           64'd0);
        chk("reset_stall",      {63'd0, stall_o},    64'd0);
        @(negedge clk);
        reset = 1'b0;

        // DIV -7 / 2 = -3; stall must hold from accept through FIX (cycles acc..acc+65)
        issue("div_neg7_2", OP_DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
              64'hFFFF_FFFF_FFFF_FFFD, 66, 1'b1, acc);
        lows = 0;
        for (int i = 0; i < 65; i++) begin
            if (!stall_o) lows++;
            @(negedge clk);
        end
        chk("div_neg7_2_stall_window", 64'(lows), 64'd0);
        #1;
        chk("div_neg7_2_done_stall", {63'd0, stall_o},    64'd0);
        chk("div_neg7_2_done_valid", {63'd0, resp_valid}, 64'd1);
        wait_done("div_neg7_2");

        // low word 0x80000007 = -2147483641 = -(16*134217727 + 9): remainder -9
        run("remw_neg",     OP_REMW,  64'h0000_0000_8000_0007, 64'h10, 64'hFFFF_FFFF_FFFF_FFF7, 34);
        run("divu_by0",     OP_DIVU,  64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        run("remu_by0",     OP_REMU,  64'd5, 64'd0, 64'd5, 1);
        run("divw_ovf",     OP_DIVW,  64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1);
        run("remw_ovf",     OP_REMW,  64'h8000_0000, 64'hFFFF_FFFF, 64'd0, 1);
        run("div_ovf64",    OP_DIV,   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
            64'h8000_0000_0000_0000, 1);
        run("rem_ovf64",    OP_REM,   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);
        run("rem_neg7_2",   OP_REM,   64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66);
        run("divuw",        OP_DIVUW, 64'hFFFF_FFFF_FFFF_FFFE, 64'd2, 64'h0000_0000_7FFF_FFFF, 34);
        run("remuw",        OP_REMUW, 64'h1_0000_0007, 64'h1_0000_0003, 64'd1, 34);
        run("divu_big",     OP_DIVU,  64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'h5555_5555_5555_5555, 66);
        run("remw_by0",     OP_REMW,  64'h0000_0000_8000_0001, 64'hFFFF_FFFF_0000_0000,
            64'hFFFF_FFFF_8000_0001, 1);
        run("divw_neg",     OP_DIVW,  64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 34);
        run("rem_pos_negb", OP_REM,   64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 66);
        run("div_pos_negb", OP_DIV,   64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF2, 66);

        // Hold the result for 5 cycles with a competing request present
        resp_ready = 1'b0;
        issue("divu_hold", OP_DIVU, 64'd100, 64'd10, 64'd10, 66, 1'b1, acc);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            #1;
            if (resp_valid) seen = 1'b1;
            else @(negedge clk);
        end
        chk("divu_hold_valid_seen", {63'd0, seen}, 64'd1);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            req_valid = 1'b1;
            req_op    = OP_DIV;
            req_a     = 64'd1;
            req_b     = 64'd1;
            #1;
            if (!resp_valid || resp_data !== 64'd10 || req_ready || stall_o) bad++;
        end
        chk("divu_hold_stable", 64'(bad), 64'd0);
        @(negedge clk);
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        wait_done("divu_hold");

        // flush and req_valid together: flush wins, nothing accepted
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = OP_DIV;
        req_a     = 64'd9;
        req_b     = 64'd3;
        flush     = 1'b1;
        #1;
        chk("flush_req_ready", {63'd0, req_ready}, 64'd0);
        @(negedge clk);
        req_valid = 1'b0;
        flush     = 1'b0;
        #1;
        chk("flush_req_not_taken", {63'd0, stall_o}, 64'd0);

        // Flush at ITER cycle 10: back to IDLE, no response ever appears
        issue("div_flushed", OP_DIV, 64'd1000, 64'd3, 64'd0, 0, 1'b0, acc);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("flush_idle_stall", {63'd0, stall_o},    64'd0);
        chk("flush_idle_valid", {63'd0, resp_valid}, 64'd0);
        hits = 0;
        repeat (80) begin
            @(negedge clk);
            #1;
            if (resp_valid) hits++;
        end
        chk("flush_no_resp", 64'(hits), 64'd0);
        run("div_after_flush", OP_DIV, 64'd100, 64'd7, 64'd14, 66);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got simulation still running, required completion within 50000 cycles");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_div_seq_ctrl
`default_nettype wire
